// File: rtl/prog_run_ctrl_pkg.sv
// Purpose: shared state encoding and size constants for the SAP-1 front-panel controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prog_run_ctrl_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;
    localparam int MEM_DEPTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

endpackage

// File: rtl/prog_run_ctrl_if.sv
// Purpose: program-load byte stream (valid/ready with end-of-program marker).
// Latency: n/a (wires only).
// Backpressure: sink holds ld_ready low whenever it is not in load mode.
//   master: board-side byte source (drives ld_valid/ld_data/ld_last)
//   slave : controller (drives ld_ready)
interface prog_run_ctrl_if
    import prog_run_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;

    modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
    modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);
endinterface

// File: rtl/prog_run_ctrl_load_addr_counter.sv
// Purpose: program-load address counter with sync clear, enable and last-address flag.
// Latency: count updates one clock after en; tc is combinational from the count.
// Backpressure: none; the caller gates en with the accepted-byte condition.
//   clk, clr (sync clear, wins over en), en -> cnt, tc (cnt == MEM_DEPTH-1)
module prog_run_ctrl_load_addr_counter
    import prog_run_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] cnt,
    output logic              tc
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + ADDR_W'(1);
        end
    end

    assign tc = (cnt == ADDR_W'(MEM_DEPTH - 1));

endmodule

// File: rtl/prog_run_ctrl.sv
// Purpose: SAP-1 front panel: loads program memory, then sequences CPU run/step/stop/halt.
// Latency: requests act at the next edge; outputs are state-decoded except mem_we (same cycle).
// Backpressure: ld_ready is high for every cycle in LOAD, low otherwise; no internal buffering.
//   clk, clr               : clock and synchronous active-high reset
//   prog_start/run_req/step_req/stop_req : panel requests (levels)
//   ld                     : program byte stream (slave side)
//   low_halt               : CPU halt, active low
//   cpu_clk_en, cpu_clr    : CPU clock gate enable and register clear
//   mem_sel/mem_we/mem_addr/mem_wdata : memory override port while loading
//   state                  : IDLE=0 LOAD=1 RUN=2 HALT=3
module prog_run_ctrl
    import prog_run_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              prog_start,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              stop_req,
    prog_run_ctrl_if.slave    ld,
    input  logic              low_halt,
    output logic              cpu_clk_en,
    output logic              cpu_clr,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        state
);

    state_t state_q, state_d;
    logic   step_q, step_d;
    logic   clr_pend_q, clr_pend_d;
    logic   cnt_clr;
    logic   cnt_tc;
    logic   accept;

    // ld_ready is high throughout LOAD, so a valid byte is accepted immediately.
    assign accept = (state_q == ST_LOAD) && ld.ld_valid;

    prog_run_ctrl_load_addr_counter #(.ADDR_W(ADDR_W)) u_addr_cnt (
        .clk (clk),
        .clr (clr || cnt_clr),
        .en  (accept),
        .cnt (mem_addr),
        .tc  (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            step_q     <= 1'b0;
            clr_pend_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = 1'b0;
        clr_pend_d = clr_pend_q;
        cnt_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // One IDLE cycle is enough to drain a pending CPU clear.
                clr_pend_d = 1'b0;
                if (prog_start) begin
                    state_d = ST_LOAD;
                    cnt_clr = 1'b1;
                end else if (run_req) begin
                    state_d = ST_RUN;
                end else if (step_req && !step_q) begin
                    // Blocking re-arm while the pulse is high makes a held
                    // request step every other cycle.
                    step_d = 1'b1;
                end
            end
            ST_LOAD: begin
                // Address 15 is always final: the counter never wraps into a rewrite.
                if (accept && (ld.ld_last || cnt_tc)) begin
                    state_d    = ST_IDLE;
                    clr_pend_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_req) begin
                    state_d = ST_IDLE;
                end else if (!low_halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (prog_start) begin
                    state_d = ST_LOAD;
                    cnt_clr = 1'b1;
                end else if (stop_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cpu_clk_en  = (state_q == ST_RUN) || step_q;
    assign cpu_clr     = (state_q == ST_LOAD) || clr_pend_q;
    assign mem_sel     = (state_q == ST_LOAD);
    assign mem_we      = accept;
    assign mem_wdata   = ld.ld_data;
    assign ld.ld_ready = (state_q == ST_LOAD);
    assign state       = state_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
module tb_prog_run_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       prog_start, run_req, step_req, stop_req, low_halt;
    logic       cpu_clk_en, cpu_clr, mem_sel, mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    int en_cnt;
    int exp_addr;
    logic [7:0] d3 [3];
    logic [6:0] pat;

    prog_run_ctrl_if #(.DATA_W(8)) ld_if ();

    prog_run_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .clr        (clr),
        .prog_start (prog_start),
        .run_req    (run_req),
        .step_req   (step_req),
        .stop_req   (stop_req),
        .ld         (ld_if.slave),
        .low_halt   (low_halt),
        .cpu_clk_en (cpu_clk_en),
        .cpu_clr    (cpu_clr),
        .mem_sel    (mem_sel),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; prog_start = 1'b0; run_req = 1'b0; step_req = 1'b0;
        stop_req = 1'b0; low_halt = 1'b1;
        ld_if.ld_valid = 1'b0; ld_if.ld_data = 8'h00; ld_if.ld_last = 1'b0;
        d3[0] = 8'h09; d3[1] = 8'h1A; d3[2] = 8'hE0;

        // Reset held for two edges
        cyc(); cyc();
        chk("rst_state",   32'(state),      32'd0);
        chk("rst_cpu_clr", 32'(cpu_clr),    32'd1);
        chk("rst_clk_en",  32'(cpu_clk_en), 32'd0);
        chk("rst_ld_rdy",  32'(ld_if.ld_ready), 32'd0);
        chk("rst_mem_sel", 32'(mem_sel),    32'd0);
        chk("rst_mem_we",  32'(mem_we),     32'd0);
        chk("rst_addr",    32'(mem_addr),   32'd0);
        clr = 1'b0;
        #1 chk("rel_cpu_clr_hold", 32'(cpu_clr), 32'd1);
        cyc();
        chk("rel_cpu_clr_low", 32'(cpu_clr), 32'd0);

        // Three-byte load with ld_last on the third
        prog_start = 1'b1; cyc(); prog_start = 1'b0;
        chk("ld3_state",   32'(state),      32'd1);
        chk("ld3_ready",   32'(ld_if.ld_ready), 32'd1);
        chk("ld3_sel",     32'(mem_sel),    32'd1);
        chk("ld3_cpu_clr", 32'(cpu_clr),    32'd1);
        chk("ld3_we_idle", 32'(mem_we),     32'd0);
        for (int i = 0; i < 3; i++) begin
            ld_if.ld_valid = 1'b1; ld_if.ld_data = d3[i]; ld_if.ld_last = (i == 2);
            #1;
            chk("ld3_we",    32'(mem_we),    32'd1);
            chk("ld3_addr",  32'(mem_addr),  32'(i));
            chk("ld3_wdata", 32'(mem_wdata), 32'(d3[i]));
            cyc();
        end
        ld_if.ld_valid = 1'b0; ld_if.ld_last = 1'b0;
        #1;
        chk("ld3_exit_state", 32'(state),   32'd0);
        chk("ld3_exit_clr",   32'(cpu_clr), 32'd1);
        chk("ld3_exit_sel",   32'(mem_sel), 32'd0);
        cyc();
        chk("ld3_clr_done",   32'(cpu_clr), 32'd0);

        // Sixteen bytes without ld_last: exit after address 15, no rewrite of 0
        prog_start = 1'b1; cyc(); prog_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ld_if.ld_valid = 1'b1; ld_if.ld_data = 8'(160 + i);
            #1;
            chk("ld16_state", 32'(state),    32'd1);
            chk("ld16_we",    32'(mem_we),   32'd1);
            chk("ld16_addr",  32'(mem_addr), 32'(i));
            cyc();
        end
        #1;
        chk("ld16_exit_state", 32'(state),  32'd0);
        chk("ld16_no_rewrite", 32'(mem_we), 32'd0);
        ld_if.ld_valid = 1'b0;
        cyc();

        // Gapped valid; panel requests must be ignored while loading
        prog_start = 1'b1; cyc(); prog_start = 1'b0;
        pat = 7'b1001101;
        exp_addr = 0;
        for (int i = 0; i < 7; i++) begin
            ld_if.ld_valid = pat[i]; ld_if.ld_data = 8'(16 * i + 3); ld_if.ld_last = (i == 6);
            run_req = 1'b1; step_req = 1'b1; stop_req = 1'b1;
            #1;
            chk("gap_state", 32'(state),      32'd1);
            chk("gap_clk_en", 32'(cpu_clk_en), 32'd0);
            chk("gap_we",    32'(mem_we),     32'(pat[i]));
            if (pat[i]) begin
                chk("gap_addr", 32'(mem_addr), 32'(exp_addr));
                exp_addr++;
            end
            cyc();
        end
        run_req = 1'b0; step_req = 1'b0; stop_req = 1'b0;
        ld_if.ld_valid = 1'b0; ld_if.ld_last = 1'b0;
        #1 chk("gap_exit_state", 32'(state), 32'd0);
        cyc();

        // Run, halt after 10 cycles, ignored requests in HALT, then stop
        run_req = 1'b1; cyc(); run_req = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (cpu_clk_en) en_cnt++;
            cyc();
        end
        low_halt = 1'b0;
        #1;
        if (cpu_clk_en) en_cnt++;
        cyc();
        low_halt = 1'b1;
        chk("run_en_cycles", 32'(en_cnt),     32'd11);
        chk("halt_state",    32'(state),      32'd3);
        chk("halt_clk_en",   32'(cpu_clk_en), 32'd0);
        chk("halt_cpu_clr",  32'(cpu_clr),    32'd0);
        run_req = 1'b1; step_req = 1'b1; cyc(); run_req = 1'b0; step_req = 1'b0;
        chk("halt_ignore_state", 32'(state),      32'd3);
        chk("halt_ignore_en",    32'(cpu_clk_en), 32'd0);
        stop_req = 1'b1; cyc(); stop_req = 1'b0;
        chk("stop_from_halt", 32'(state), 32'd0);

        // Stop beats halt in the same RUN cycle
        run_req = 1'b1; cyc(); run_req = 1'b0;
        chk("run2_state", 32'(state), 32'd2);
        stop_req = 1'b1; low_halt = 1'b0; cyc(); stop_req = 1'b0; low_halt = 1'b1;
        chk("stop_wins", 32'(state), 32'd0);

        // Single step pulse
        step_req = 1'b1; cyc(); step_req = 1'b0;
        chk("step_en",    32'(cpu_clk_en), 32'd1);
        chk("step_state", 32'(state),      32'd0);
        cyc();
        chk("step_en_off", 32'(cpu_clk_en), 32'd0);

        // Held step request: one step every other cycle
        step_req = 1'b1;
        en_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (cpu_clk_en) en_cnt++;
        end
        step_req = 1'b0;
        chk("step_held", 32'(en_cnt), 32'd2);
        cyc();

        // prog_start has priority over run_req
        prog_start = 1'b1; run_req = 1'b1; cyc(); prog_start = 1'b0; run_req = 1'b0;
        chk("prio_load", 32'(state), 32'd1);

        // clr while loading aborts the load and zeroes the counter
        ld_if.ld_valid = 1'b1; ld_if.ld_data = 8'h55; cyc(); cyc();
        #1 chk("abort_pre_addr", 32'(mem_addr), 32'd2);
        ld_if.ld_valid = 1'b0;
        clr = 1'b1; cyc(); clr = 1'b0;
        chk("abort_state",   32'(state),    32'd0);
        chk("abort_addr",    32'(mem_addr), 32'd0);
        chk("abort_cpu_clr", 32'(cpu_clr),  32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_run_ctrl.md
# prog_run_ctrl

Front-panel controller for the SAP-1 computer. It owns the 16x8 program memory while a program is loaded byte-by-byte over a valid/ready port, then hands memory back to the CPU's MAR path. It sequences CPU execution as free-run, single T-state step, or stop, and reacts to the CPU halt signal. It sits between the board I/O and the top-level clock gate, CPU clear, and memory write/select inputs.

## Interface
- ADDR_W, 4, memory address width
- DATA_W, 8, memory word width
- clk  in  1  system clock, all logic on rising edge
- clr  in  1  synchronous, active-high reset
- prog_start  in  1  request to enter load mode (level, sampled each cycle)
- run_req  in  1  request free-run
- step_req  in  1  request one CPU T-state
- stop_req  in  1  return to idle from RUN/HALT
- ld_valid  in  1  load byte valid
- ld_data  in  DATA_W  load byte
- ld_last  in  1  qualifies final byte of program
- ld_ready  out  1  loader accepts byte
- low_halt  in  1  CPU halt, active-low (from control sequencer)
- cpu_clk_en  out  1  enable for CPU clock gate
- cpu_clr  out  1  synchronous clear to CPU registers/PC
- mem_sel  out  1  1 = controller drives memory addr/data, 0 = CPU MAR
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  load address
- mem_wdata  out  DATA_W  load data
- state  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3

## Operation
- Reset (clr=1 at edge): state=IDLE, load address counter=0, step pulse=0, clear-pending=1. Reset outputs: cpu_clk_en=0, cpu_clr=1, mem_sel=0, mem_we=0, ld_ready=0, mem_addr=0.
- IDLE: priority prog_start > run_req > step_req.
  - prog_start -> LOAD, address counter=0.
  - run_req -> RUN.
  - step_req -> step pulse register set for exactly one cycle, then cleared; state stays IDLE. step_req held high gives one step per 2 cycles (pulse, then re-arm on deassert-free sampling is not required; a held request re-triggers every other cycle).
- LOAD: mem_sel=1, ld_ready=1, cpu_clr=1, cpu_clk_en=0.
  - Accept when ld_valid & ld_ready: mem_we=1 same cycle (combinational), mem_addr=counter, mem_wdata=ld_data; counter increments at edge.
  - Exit to IDLE on the accepting cycle if ld_last=1 or counter=15. No wrap: byte at address 15 is always final.
  - run_req/step_req/stop_req ignored.
- RUN: cpu_clk_en=1. low_halt=0 -> HALT. stop_req -> IDLE (stop wins over halt in the same cycle). prog_start ignored.
- HALT: cpu_clk_en=0. prog_start -> LOAD; stop_req -> IDLE; run_req/step_req ignored. Only LOAD or clr re-initialises the CPU.
- cpu_clr = (state==LOAD) | clear-pending. clear-pending set by reset and on LOAD->IDLE exit; cleared after one IDLE cycle.
- mem_sel=0 and mem_we=0 in every state except LOAD.

## Timing
- State transitions take effect at the edge after the request is sampled; outputs decoded from state (Moore) except mem_we.
- prog_start at edge N -> ld_ready=1 in cycle N+1.
- run_req at edge N -> cpu_clk_en=1 from N+1.
- low_halt low during RUN cycle N -> cpu_clk_en=0 from N+1 (CPU gets exactly the cycle in which it raised halt).
- step_req at edge N -> cpu_clk_en=1 for cycle N+1 only.
- Final load byte accepted at N -> cycle N+1: IDLE, cpu_clr=1, mem_sel=0; cycle N+2: cpu_clr=0.
- clr mid-LOAD: LOAD aborted, memory contents already written are kept, counter=0.

## Structure
- Shared package: state encoding constants (IDLE/LOAD/RUN/HALT), ADDR_W/DATA_W defaults, MEM_DEPTH=16.
- One sub-module natural: load_addr_counter (4-bit counter, sync clear, enable, terminal-count flag).

## Test plan
- Reset: hold clr 2 cycles -> state=0, cpu_clr=1, cpu_clk_en=0, ld_ready=0; one cycle after release cpu_clr=0.
- Load 3 bytes 0x09,0x1A,0xE0 with ld_last on 3rd -> mem_we at addr 0,1,2 with those data, then IDLE with one-cycle cpu_clr.
- Load 16 bytes, ld_last never set -> write addr 0..15, exit after addr 15, no write to addr 0 again.
- ld_valid toggling with gaps during LOAD -> writes only on valid cycles, addresses contiguous.
- run_req, then low_halt=0 after 10 cycles -> cpu_clk_en high 11 cycles, state=3; stop_req -> state=0.
- step_req single-cycle in IDLE -> cpu_clk_en high exactly 1 cycle; prog_start+run_req same cycle -> LOAD.
